// File: rtl/mem_sweep_pkg.sv
// Shared types and signature step for the memory sweep checker.
// Optional write-pattern mode is enabled by SWEEP_WRITE_EN.
package mem_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } sweep_state_t;

  localparam int SIG_MAX = 64;
  typedef logic [SIG_MAX-1:0] sig_word_t;

  localparam sig_word_t SIG_RESET = '0;

  // Rotate-left-by-one of the low w bits, then XOR in the word.
  function automatic sig_word_t sig_step(
    input sig_word_t   sig,
    input sig_word_t   word,
    input int unsigned w
  );
    sig_word_t m;
    sig_word_t r;
    if (w >= SIG_MAX) m = '1;
    else m = (sig_word_t'(1) << w) - sig_word_t'(1);
    r = (sig << 1) | (sig >> (w - 1));
    return (r ^ word) & m;
  endfunction

endpackage

// File: rtl/mem_sweep_checker_if.sv
// Memory-side bus of the sweep checker: read/write address and data.
// Optional write-pattern mode is enabled by SWEEP_WRITE_EN.
interface mem_sweep_checker_if #(
  parameter int AW      = 13,
  parameter int WID_MEM = 9
);
  logic [AW-1:0]      raddr;
  logic [AW-1:0]      waddr;
  logic [WID_MEM-1:0] din;
  logic [WID_MEM-1:0] dout;

  modport master (
    output raddr,
    output waddr,
    output din,
    input  dout
  );

  modport slave (
    input  raddr,
    input  waddr,
    input  din,
    output dout
  );
endinterface

// File: rtl/mem_sweep_sig_accum.sv
// Rotate-XOR signature and word counter, cleared at sweep start.
// Optional write-pattern mode of the top is enabled by SWEEP_WRITE_EN.
module mem_sweep_sig_accum
  import mem_sweep_pkg::*;
#(
  parameter int WID   = 9,
  parameter int SIG_W = 32,
  parameter int CW    = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [WID-1:0]   word,
  output logic [SIG_W-1:0] sig,
  output logic [CW-1:0]    count
);

  logic [SIG_W-1:0] sig_d, sig_q;
  logic [CW-1:0]    cnt_d, cnt_q;

  always_comb begin
    sig_d = sig_q;
    cnt_d = cnt_q;
    if (clear) begin
      sig_d = SIG_RESET[SIG_W-1:0];
      cnt_d = '0;
    end else if (valid) begin
      sig_d = SIG_W'(sig_step(sig_word_t'(sig_q),
                              sig_word_t'(word),
                              SIG_W));
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sig_q <= SIG_RESET[SIG_W-1:0];
      cnt_q <= '0;
    end else begin
      sig_q <= sig_d;
      cnt_q <= cnt_d;
    end
  end

  assign sig   = sig_q;
  assign count = cnt_q;

endmodule

// File: rtl/mem_sweep_checker.sv
// Sweeps a BRAM, writing each word back and folding reads into a signature.
// SWEEP_WRITE_EN adds wr_mode/wr_seed to overwrite memory with a pattern.
module mem_sweep_checker
  import mem_sweep_pkg::*;
#(
  parameter int WID_MEM   = 9,
  parameter int DEPTH_MEM = 8192,
  parameter int AW        = $clog2(DEPTH_MEM),
  parameter int PARK_ADDR = DEPTH_MEM - 1,
  parameter int SIG_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef SWEEP_WRITE_EN
  input  logic               wr_mode,
  input  logic [WID_MEM-1:0] wr_seed,
`endif
  mem_sweep_checker_if.master mem,
  output logic               busy,
  output logic               done,
  output logic [SIG_W-1:0]   signature,
  output logic [AW:0]        word_count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH_MEM - 1);
  localparam logic [AW-1:0] PARK = AW'(PARK_ADDR);

  sweep_state_t  state_d, state_q;
  logic [AW-1:0] raddr_d, raddr_q;
  logic [AW-1:0] waddr_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          vld_q;
  logic          clear;

  always_comb begin
    state_d = state_q;
    raddr_d = PARK;
    clear   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SWEEP;
          raddr_d = '0;
          clear   = 1'b1;
        end
      end
      SWEEP: begin
        if (raddr_q == LAST) state_d = DRAIN;
        else raddr_d = raddr_q + 1'b1;
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SWEEP) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // vld_q marks the cycle in which dout carries the word addressed last cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      raddr_q <= PARK;
      waddr_q <= PARK;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      waddr_q <= raddr_q;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= (state_q == SWEEP);
    end
  end

`ifdef SWEEP_WRITE_EN
  logic               wm_d, wm_q;
  logic [WID_MEM-1:0] seed_d, seed_q;
  logic               wr_act;

  always_comb begin
    wm_d   = wm_q;
    seed_d = seed_q;
    if (clear) begin
      wm_d   = wr_mode;
      seed_d = wr_seed;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wm_q   <= 1'b0;
      seed_q <= '0;
    end else begin
      wm_q   <= wm_d;
      seed_q <= seed_d;
    end
  end

  // DRAIN keeps writing the pattern so the parked word is not reverted.
  assign wr_act    = wm_q && busy_q;
  assign mem.waddr = wr_act ? raddr_q : waddr_q;
  assign mem.din   = wr_act ? (WID_MEM'(raddr_q) ^ seed_q)
                            : mem.dout;
`else
  assign mem.waddr = waddr_q;
  assign mem.din   = mem.dout;
`endif

  assign mem.raddr = raddr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  mem_sweep_sig_accum #(
    .WID   (WID_MEM),
    .SIG_W (SIG_W),
    .CW    (AW + 1)
  ) u_accum (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .valid (vld_q),
    .word  (mem.dout),
    .sig   (signature),
    .count (word_count)
  );

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Bench for mem_sweep_checker: small and full-size instances with BRAM models.
// Write-pattern scenario runs only when SWEEP_WRITE_EN is defined.
module tb_mem_sweep_checker;

  localparam int W   = 9;
  localparam int DA  = 8;
  localparam int AWA = 3;
  localparam int DB  = 8192;
  localparam int AWB = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;
  logic [31:0] sig_a, sig_b;
  logic [AWA:0] wc_a;
  logic [AWB:0] wc_b;
  logic wr_mode_a, wr_mode_b;
  logic [W-1:0] wr_seed_a, wr_seed_b;

  mem_sweep_checker_if #(.AW(AWA), .WID_MEM(W)) ma ();
  mem_sweep_checker_if #(.AW(AWB), .WID_MEM(W)) mb ();

  bit [W-1:0] ram_a [DA];
  bit [W-1:0] ram_b [DB];
  bit [W-1:0] img_a [DA];
  bit [W-1:0] img_b [DB];
  bit [W-1:0] dout_a, dout_b;
  logic ld_a, ld_b;
  logic [AWA-1:0] lda_addr;
  logic [AWB-1:0] ldb_addr;
  logic [W-1:0] lda_data, ldb_data;

  assign ma.dout = dout_a;
  assign mb.dout = dout_b;

  // BRAM models: registered read, unconditional write, plus a backdoor load.
  always @(posedge clk) begin
    if (ld_a) begin
      ram_a[lda_addr] <= lda_data;
      if (lda_addr == AWA'(DA - 1)) dout_a <= lda_data;
    end else begin
      dout_a <= ram_a[ma.raddr];
      ram_a[ma.waddr] <= ma.din;
    end
  end

  always @(posedge clk) begin
    if (ld_b) begin
      ram_b[ldb_addr] <= ldb_data;
      if (ldb_addr == AWB'(DB - 1)) dout_b <= ldb_data;
    end else begin
      dout_b <= ram_b[mb.raddr];
      ram_b[mb.waddr] <= mb.din;
    end
  end

  mem_sweep_checker #(
    .WID_MEM(W), .DEPTH_MEM(DA), .AW(AWA),
    .PARK_ADDR(DA - 1), .SIG_W(32)
  ) u_a (
    .clk(clk), .reset(rst_a), .start(start_a),
`ifdef SWEEP_WRITE_EN
    .wr_mode(wr_mode_a), .wr_seed(wr_seed_a),
`endif
    .mem(ma.master), .busy(busy_a), .done(done_a),
    .signature(sig_a), .word_count(wc_a)
  );

  mem_sweep_checker #(
    .WID_MEM(W), .DEPTH_MEM(DB), .AW(AWB),
    .PARK_ADDR(DB - 1), .SIG_W(32)
  ) u_b (
    .clk(clk), .reset(rst_b), .start(start_b),
`ifdef SWEEP_WRITE_EN
    .wr_mode(wr_mode_b), .wr_seed(wr_seed_b),
`endif
    .mem(mb.master), .busy(busy_b), .done(done_b),
    .signature(sig_b), .word_count(wc_b)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference signature: rotate left by one, XOR in each word in address order.
  function automatic logic [31:0] fold_a();
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < DA; i++)
      s = ((s << 1) | (s >> 31)) ^ {23'd0, img_a[i]};
    return s;
  endfunction

  function automatic logic [31:0] fold_b();
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < DB; i++)
      s = ((s << 1) | (s >> 31)) ^ {23'd0, img_b[i]};
    return s;
  endfunction

  task automatic load_a();
    for (int i = 0; i < DA; i++) begin
      @(negedge clk);
      ld_a = 1'b1;
      lda_addr = AWA'(i);
      lda_data = img_a[i];
    end
    @(negedge clk);
    ld_a = 1'b0;
  endtask

  task automatic load_b();
    for (int i = 0; i < DB; i++) begin
      @(negedge clk);
      ld_b = 1'b1;
      ldb_addr = AWB'(i);
      ldb_data = img_b[i];
    end
    @(negedge clk);
    ld_b = 1'b0;
  endtask

  task automatic sweep_a(output int cyc);
    @(negedge clk);
    start_a = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      cyc++;
    end while (!done_a && cyc < 100);
  endtask

  task automatic sweep_b(output int cyc);
    @(negedge clk);
    start_b = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start_b = 1'b0;
      cyc++;
    end while (!done_b && cyc < 9000);
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    ld_a = 1'b0; ld_b = 1'b0;
    lda_addr = '0; ldb_addr = '0;
    lda_data = '0; ldb_data = '0;
    wr_mode_a = 1'b0; wr_mode_b = 1'b0;
    wr_seed_a = '0; wr_seed_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags_a got busy=%b done=%b want 0 0", busy_a, done_a);
    end
    n_checks++;
    if (ma.raddr !== AWA'(DA - 1) || ma.waddr !== AWA'(DA - 1)) begin
      n_fail++;
      $display("FAIL rst_addr_a got r=%0d w=%0d want %0d", ma.raddr, ma.waddr, DA - 1);
    end
    n_checks++;
    if (sig_a !== 32'd0 || wc_a !== '0) begin
      n_fail++;
      $display("FAIL rst_sig_a got sig=%h wc=%0d want 0 0", sig_a, wc_a);
    end
    n_checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags_b got busy=%b done=%b want 0 0", busy_b, done_b);
    end
    n_checks++;
    if (mb.raddr !== AWB'(DB - 1) || mb.waddr !== AWB'(DB - 1)) begin
      n_fail++;
      $display("FAIL rst_addr_b got r=%0d w=%0d want %0d", mb.raddr, mb.waddr, DB - 1);
    end
    n_checks++;
    if (sig_b !== 32'd0 || wc_b !== '0) begin
      n_fail++;
      $display("FAIL rst_sig_b got sig=%h wc=%0d want 0 0", sig_b, wc_b);
    end
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero();
    int cyc;
    sweep_a(cyc);
    n_checks++;
    if (cyc !== DA + 2) begin
      n_fail++;
      $display("FAIL zero_latency got %0d want %0d", cyc, DA + 2);
    end
    n_checks++;
    if (sig_a !== 32'd0 || wc_a !== (AWA + 1)'(DA)) begin
      n_fail++;
      $display("FAIL zero_result got sig=%h wc=%0d want 0 %0d", sig_a, wc_a, DA);
    end
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy got %b want 0", busy_a);
    end
  endtask

  task automatic test_single_words();
    int cyc;
    img_a[0] = 9'h001;
    load_a();
    sweep_a(cyc);
    n_checks++;
    if (sig_a !== 32'h0000_0080 || sig_a !== fold_a()) begin
      n_fail++;
      $display("FAIL first_word got %h want %h", sig_a, 32'h80);
    end
    img_a[0] = 9'h000;
    img_a[DA-1] = 9'h1FF;
    load_a();
    sweep_a(cyc);
    n_checks++;
    if (sig_a !== 32'h0000_01FF || sig_a !== fold_a()) begin
      n_fail++;
      $display("FAIL last_word got %h want %h", sig_a, 32'h1FF);
    end
  endtask

  task automatic test_random();
    int cyc, bad;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DA; i++) img_a[i] = W'($urandom);
      load_a();
      sweep_a(cyc);
      n_checks++;
      if (sig_a !== fold_a() || cyc !== DA + 2) begin
        n_fail++;
        $display("FAIL rand_sig[%0d] got %h/%0d want %h/%0d", t, sig_a, cyc, fold_a(), DA + 2);
      end
      bad = 0;
      for (int i = 0; i < DA; i++) if (ram_a[i] !== img_a[i]) bad++;
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL rand_image[%0d] got %0d changed words want 0", t, bad);
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    logic [31:0] exp;
    exp = fold_a();
    @(negedge clk);
    start_a = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start_a = (cyc == 4 || cyc == 7);
    end while (!done_a && cyc < 100);
    start_a = 1'b0;
    n_checks++;
    if (cyc !== DA + 2 || sig_a !== exp) begin
      n_fail++;
      $display("FAIL busy_start got %0d/%h want %0d/%h", cyc, sig_a, DA + 2, exp);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || sig_a !== exp) begin
      n_fail++;
      $display("FAIL done_hold got done=%b busy=%b sig=%h want 1 0 %h", done_a, busy_a, sig_a, exp);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < DA; i++) img_a[i] = W'($urandom);
    load_a();
    @(negedge clk);
    start_a = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_a && cyc < 100);
    n_checks++;
    if (sig_a !== fold_a()) begin
      n_fail++;
      $display("FAIL b2b_sig1 got %h want %h", sig_a, fold_a());
    end
    @(negedge clk);
    n_checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap got done=%b busy=%b want 0 1", done_a, busy_a);
    end
    cyc = 1;
    while (!done_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    n_checks++;
    if (cyc !== DA + 2 || sig_a !== fold_a()) begin
      n_fail++;
      $display("FAIL b2b_sig2 got %0d/%h want %0d/%h", cyc, sig_a, DA + 2, fold_a());
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef SWEEP_WRITE_EN
  task automatic test_write_mode();
    int cyc, bad;
    logic [W-1:0] seed;
    seed = 9'h0AA;
    for (int i = 0; i < DA; i++) img_a[i] = W'($urandom);
    load_a();
    wr_mode_a = 1'b1;
    wr_seed_a = seed;
    sweep_a(cyc);
    wr_mode_a = 1'b0;
    wr_seed_a = '0;
    n_checks++;
    if (sig_a !== fold_a()) begin
      n_fail++;
      $display("FAIL wr_old_sig got %h want %h", sig_a, fold_a());
    end
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < DA; i++) begin
      img_a[i] = W'(i) ^ seed;
      if (ram_a[i] !== img_a[i]) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL wr_pattern got %0d bad words want 0", bad);
    end
    sweep_a(cyc);
    n_checks++;
    if (sig_a !== fold_a()) begin
      n_fail++;
      $display("FAIL wr_new_sig got %h want %h", sig_a, fold_a());
    end
  endtask
`endif

  task automatic test_integrity();
    int cyc, bad;
    logic [31:0] s1;
    for (int i = 0; i < DB; i++) img_b[i] = W'($urandom);
    load_b();
    sweep_b(cyc);
    s1 = sig_b;
    n_checks++;
    if (s1 !== fold_b() || cyc !== DB + 2 || wc_b !== (AWB + 1)'(DB)) begin
      n_fail++;
      $display("FAIL big_sweep1 got %h/%0d/%0d want %h/%0d/%0d", s1, cyc, wc_b, fold_b(), DB + 2, DB);
    end
    sweep_b(cyc);
    n_checks++;
    if (sig_b !== s1) begin
      n_fail++;
      $display("FAIL big_sweep2 got %h want %h", sig_b, s1);
    end
    bad = 0;
    for (int i = 0; i < DB; i++) if (ram_b[i] !== img_b[i]) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL big_image got %0d changed words want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (99) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || mb.raddr !== AWB'(DB - 1)) begin
      n_fail++;
      $display("FAIL midrst_state got busy=%b done=%b raddr=%0d want 0 0 %0d", busy_b, done_b, mb.raddr, DB - 1);
    end
    n_checks++;
    if (sig_b !== 32'd0 || wc_b !== '0) begin
      n_fail++;
      $display("FAIL midrst_sig got sig=%h wc=%0d want 0 0", sig_b, wc_b);
    end
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle got busy=%b done=%b want 0 0", busy_b, done_b);
    end
    bad = 0;
    for (int i = 0; i < DB - 1; i++) if (ram_b[i] !== img_b[i]) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midrst_image got %0d changed words want 0", bad);
    end
    @(negedge clk);
    ld_b = 1'b1;
    ldb_addr = AWB'(DB - 1);
    ldb_data = img_b[DB-1];
    @(negedge clk);
    ld_b = 1'b0;
    sweep_b(cyc);
    n_checks++;
    if (sig_b !== fold_b() || cyc !== DB + 2 || wc_b !== (AWB + 1)'(DB)) begin
      n_fail++;
      $display("FAIL midrst_rerun got %h/%0d/%0d want %h/%0d/%0d", sig_b, cyc, wc_b, fold_b(), DB + 2, DB);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_words();
    test_random();
    test_start_ignored();
    test_back_to_back();
`ifdef SWEEP_WRITE_EN
    test_write_mode();
`endif
    test_integrity();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
